// File: rtl/mem_readback.sv
// Read-back engine: streams a block of words from a 512x16 memory out of one pad as
// UART-style frames (start 0, DATA_W bits LSB first, stop 1).
module mem_readback #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned DATA_W       = 16
) (
    input  logic              soc_clk,
    input  logic              soc_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic [ADDR_W-1:0] addr_to_mem,
    output logic              en_to_memB,
    output logic              rw_to_mem,
    input  logic [DATA_W-1:0] data_from_mem,
    output logic              tx_out,
    output logic              io_oeb,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_sent
);

    localparam int unsigned BIT_W = $clog2(DATA_W + 2);

    localparam logic [15:0]       DIV_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W + 1);
    localparam logic [BIT_W-1:0]  BIT_ONE  = {{(BIT_W - 1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WORD_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W - 1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StCapt,
        StShift,
        StDone
    } state_e;

    state_e            state_q;
    logic [15:0]       div_q;
    logic [BIT_W-1:0]  bit_q;
    logic [DATA_W:0]   shreg_q;
    logic [ADDR_W:0]   left_q;

    // Read-only engine: the write strobe is never asserted.
    assign rw_to_mem = 1'b1;

    always_ff @(posedge soc_clk) begin
        if (soc_rst) begin
            state_q     <= StIdle;
            div_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            left_q      <= '0;
            addr_to_mem <= '0;
            en_to_memB  <= 1'b1;
            tx_out      <= 1'b1;
            io_oeb      <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            words_sent  <= '0;
        end else if (abort && (state_q != StIdle)) begin
            state_q    <= StIdle;
            en_to_memB <= 1'b1;
            tx_out     <= 1'b1;
            io_oeb     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // An abort in the same cycle drops the start.
                    if (start && !abort) begin
                        busy       <= 1'b1;
                        io_oeb     <= 1'b0;
                        words_sent <= '0;
                        if (word_count != '0) begin
                            addr_to_mem <= start_addr;
                            left_q      <= word_count;
                            en_to_memB  <= 1'b0;
                            state_q     <= StReq;
                        end else begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StReq: begin
                    en_to_memB <= 1'b1;
                    state_q    <= StCapt;
                end
                StCapt: begin
                    shreg_q <= {1'b1, data_from_mem};
                    tx_out  <= 1'b0;
                    div_q   <= '0;
                    bit_q   <= '0;
                    state_q <= StShift;
                end
                StShift: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            words_sent <= words_sent + WORD_ONE;
                            left_q     <= left_q - WORD_ONE;
                            tx_out     <= 1'b1;
                            if (left_q == WORD_ONE) begin
                                done    <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                addr_to_mem <= addr_to_mem + ADDR_ONE;
                                en_to_memB  <= 1'b0;
                                state_q     <= StReq;
                            end
                        end else begin
                            // Stop bit is pre-loaded above the data, so it shifts out last.
                            tx_out  <= shreg_q[0];
                            shreg_q <= {1'b1, shreg_q[DATA_W:1]};
                            bit_q   <= bit_q + BIT_ONE;
                        end
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    io_oeb  <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_readback.sv
// Self-checking bench for mem_readback: directed scenarios plus randomized transfers
// checked cycle by cycle against a frame-timing model.
module tb_mem_readback;

    localparam int C = 4;
    localparam int P = 2 + 18 * C;

    logic        soc_clk = 1'b0;
    logic        soc_rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [8:0]  start_addr = '0;
    logic [9:0]  word_count = '0;
    logic [8:0]  addr_to_mem;
    logic        en_to_memB;
    logic        rw_to_mem;
    logic [15:0] data_from_mem = '0;
    logic        tx_out;
    logic        io_oeb;
    logic        busy;
    logic        done;
    logic [9:0]  words_sent;

    logic [15:0] mem [512];

    int total = 0;
    int bad = 0;

    logic       q_tx[$];
    logic       q_en[$];
    logic       q_busy[$];
    logic       q_oeb[$];
    logic [8:0] q_addr[$];
    logic [9:0] q_ws[$];
    int         done_cyc;
    int         n_done;

    mem_readback #(
        .CLKS_PER_BIT(C),
        .ADDR_W      (9),
        .DATA_W      (16)
    ) dut (
        .soc_clk      (soc_clk),
        .soc_rst      (soc_rst),
        .start        (start),
        .abort        (abort),
        .start_addr   (start_addr),
        .word_count   (word_count),
        .addr_to_mem  (addr_to_mem),
        .en_to_memB   (en_to_memB),
        .rw_to_mem    (rw_to_mem),
        .data_from_mem(data_from_mem),
        .tx_out       (tx_out),
        .io_oeb       (io_oeb),
        .busy         (busy),
        .done         (done),
        .words_sent   (words_sent)
    );

    always #5 soc_clk = ~soc_clk;

    // Synchronous-read memory: data appears the cycle after the active-low enable.
    always @(posedge soc_clk) begin
        if (en_to_memB == 1'b0) data_from_mem <= mem[addr_to_mem];
    end

    always @(negedge soc_clk) begin
        total++;
        if (rw_to_mem !== 1'b1) begin
            bad++;
            $display("FAIL rw_to_mem got=%b want=1 at %0t", rw_to_mem, $time);
        end
    end

    // Model: expected pad level in cycle c of a transfer started (accepted) in cycle 0.
    function automatic logic exp_tx(int c, int sa, int wc);
        int k;
        int o;
        int b;
        logic [15:0] w;
        if (c < 1 || c >= 1 + wc * P) return 1'b1;
        k = (c - 1) / P;
        o = (c - 1) % P;
        if (o < 2) return 1'b1;
        b = (o - 2) / C;
        w = mem[(sa + k) % 512];
        if (b == 0) return 1'b0;
        if (b <= 16) return w[b - 1];
        return 1'b1;
    endfunction

    function automatic logic exp_en(int c, int wc);
        if (c >= 1 && c < 1 + wc * P && ((c - 1) % P) == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge soc_clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 (the cycle after the accepting edge).
    task automatic pulse_start(input int sa, input int wc);
        start_addr = 9'(sa);
        word_count = 10'(wc);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Records cycles 1..n; optionally pulses a stray start during cycle inj.
    task automatic capture(input int n, input int inj, input int inj_addr);
        q_tx.delete(); q_en.delete(); q_busy.delete(); q_oeb.delete();
        q_addr.delete(); q_ws.delete();
        q_tx.push_back(1'b1); q_en.push_back(1'b1); q_busy.push_back(1'b0);
        q_oeb.push_back(1'b1); q_addr.push_back('0); q_ws.push_back('0);
        done_cyc = -1;
        n_done = 0;
        for (int c = 1; c <= n; c++) begin
            if (c > 1) begin
                tick();
                start = 1'b0;
            end
            q_tx.push_back(tx_out); q_en.push_back(en_to_memB); q_busy.push_back(busy);
            q_oeb.push_back(io_oeb); q_addr.push_back(addr_to_mem); q_ws.push_back(words_sent);
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == inj) begin
                start = 1'b1;
                start_addr = 9'(inj_addr);
                word_count = 10'd5;
            end
        end
    endtask

    task automatic test_reset();
        soc_rst = 1'b1;
        tick();
        tick();
        total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx_out); end
        total++; if (io_oeb !== 1'b1) begin bad++; $display("FAIL reset_oeb got=%b want=1", io_oeb); end
        total++; if (en_to_memB !== 1'b1) begin bad++; $display("FAIL reset_en got=%b want=1", en_to_memB); end
        total++; if (addr_to_mem !== 9'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", addr_to_mem); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (words_sent !== 10'd0) begin bad++; $display("FAIL reset_ws got=%0d want=0", words_sent); end
        soc_rst = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        logic [15:0] exp_w;
        exp_w = 16'hA5C3;
        mem[5] = exp_w;
        pulse_start(5, 1);
        capture(P + 6, -1, 0);
        total++; if (q_en[1] !== 1'b0) begin bad++; $display("FAIL single_req_en got=%b want=0", q_en[1]); end
        total++; if (q_addr[1] !== 9'd5) begin bad++; $display("FAIL single_req_addr got=%0d want=5", q_addr[1]); end
        total++; if (q_en[2] !== 1'b1) begin bad++; $display("FAIL single_capt_en got=%b want=1", q_en[2]); end
        for (int c = 3; c <= 6; c++) begin
            total++;
            if (q_tx[c] !== 1'b0) begin bad++; $display("FAIL single_startbit c=%0d got=%b want=0", c, q_tx[c]); end
        end
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < C; j++) begin
                total++;
                if (q_tx[7 + C * i + j] !== exp_w[i]) begin
                    bad++;
                    $display("FAIL single_data bit=%0d c=%0d got=%b want=%b", i, 7 + C * i + j,
                             q_tx[7 + C * i + j], exp_w[i]);
                end
            end
        end
        for (int c = 71; c <= 74; c++) begin
            total++;
            if (q_tx[c] !== 1'b1) begin bad++; $display("FAIL single_stopbit c=%0d got=%b want=1", c, q_tx[c]); end
        end
        total++; if (done_cyc != 75) begin bad++; $display("FAIL single_done_cycle got=%0d want=75", done_cyc); end
        total++; if (n_done != 1) begin bad++; $display("FAIL single_done_pulses got=%0d want=1", n_done); end
        total++; if (q_ws[75] !== 10'd1) begin bad++; $display("FAIL single_ws got=%0d want=1", q_ws[75]); end
        total++; if (q_busy[P + 6] !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", q_busy[P + 6]); end
    endtask

    task automatic test_wrap();
        int          req_c[$];
        logic [8:0]  req_a[$];
        logic [8:0]  want_a[3];
        logic [15:0] w;
        want_a[0] = 9'd510; want_a[1] = 9'd511; want_a[2] = 9'd0;
        mem[510] = 16'd1; mem[511] = 16'd2; mem[0] = 16'd3;
        pulse_start(510, 3);
        capture(3 * P + 6, -1, 0);
        for (int c = 1; c < q_en.size(); c++) begin
            if (q_en[c] === 1'b0) begin
                req_c.push_back(c);
                req_a.push_back(q_addr[c]);
            end
        end
        total++;
        if (req_c.size() != 3) begin bad++; $display("FAIL wrap_req_count got=%0d want=3", req_c.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (req_c[k] != 1 + k * P) begin bad++; $display("FAIL wrap_req_cycle k=%0d got=%0d want=%0d", k, req_c[k], 1 + k * P); end
                total++;
                if (req_a[k] !== want_a[k]) begin bad++; $display("FAIL wrap_req_addr k=%0d got=%0d want=%0d", k, req_a[k], want_a[k]); end
            end
        end
        for (int k = 0; k < 3; k++) begin
            w = '0;
            for (int i = 0; i < 16; i++) w[i] = q_tx[1 + k * P + 2 + C * (1 + i) + C / 2];
            total++;
            if (w !== 16'(k + 1)) begin bad++; $display("FAIL wrap_word k=%0d got=%0d want=%0d", k, w, k + 1); end
        end
        total++; if (q_ws[1 + 3 * P] !== 10'd3) begin bad++; $display("FAIL wrap_ws got=%0d want=3", q_ws[1 + 3 * P]); end
        total++; if (n_done != 1) begin bad++; $display("FAIL wrap_done_pulses got=%0d want=1", n_done); end
        total++; if (done_cyc != 1 + 3 * P) begin bad++; $display("FAIL wrap_done_cycle got=%0d want=%0d", done_cyc, 1 + 3 * P); end
    endtask

    task automatic test_zero_count();
        pulse_start(123, 0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", done); end
        total++; if (io_oeb !== 1'b0) begin bad++; $display("FAIL zero_oeb got=%b want=0", io_oeb); end
        total++; if (en_to_memB !== 1'b1) begin bad++; $display("FAIL zero_en got=%b want=1", en_to_memB); end
        total++; if (words_sent !== 10'd0) begin bad++; $display("FAIL zero_ws got=%0d want=0", words_sent); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy got=%b want=1", busy); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_after got=%b want=0", done); end
        total++; if (io_oeb !== 1'b1) begin bad++; $display("FAIL zero_oeb_after got=%b want=1", io_oeb); end
        total++; if (en_to_memB !== 1'b1) begin bad++; $display("FAIL zero_en_after got=%b want=1", en_to_memB); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_abort();
        int          dones;
        logic [15:0] w;
        mem[40] = 16'($urandom);
        pulse_start(40, 2);
        repeat (19) tick();
        total++;
        if (tx_out !== exp_tx(20, 40, 2)) begin bad++; $display("FAIL abort_pre_tx got=%b want=%b", tx_out, exp_tx(20, 40, 2)); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL abort_tx got=%b want=1", tx_out); end
        total++; if (io_oeb !== 1'b1) begin bad++; $display("FAIL abort_oeb got=%b want=1", io_oeb); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (en_to_memB !== 1'b1) begin bad++; $display("FAIL abort_en got=%b want=1", en_to_memB); end
        total++; if (words_sent !== 10'd0) begin bad++; $display("FAIL abort_ws got=%0d want=0", words_sent); end
        dones = 0;
        for (int c = 0; c < 2 * P; c++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            tick();
        end
        total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
        // Start and abort together in IDLE: the start must be dropped.
        start = 1'b1; abort = 1'b1; start_addr = 9'd40; word_count = 10'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_start_busy got=%b want=0", busy); end
        total++; if (io_oeb !== 1'b1) begin bad++; $display("FAIL abort_start_oeb got=%b want=1", io_oeb); end
        total++; if (en_to_memB !== 1'b1) begin bad++; $display("FAIL abort_start_en got=%b want=1", en_to_memB); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_start_busy2 got=%b want=0", busy); end
        pulse_start(40, 1);
        capture(P + 6, -1, 0);
        w = '0;
        for (int i = 0; i < 16; i++) w[i] = q_tx[3 + C * (1 + i) + C / 2];
        total++; if (w !== mem[40]) begin bad++; $display("FAIL abort_fresh_word got=%h want=%h", w, mem[40]); end
        total++; if (done_cyc != 1 + P) begin bad++; $display("FAIL abort_fresh_done got=%0d want=%0d", done_cyc, 1 + P); end
        total++; if (q_ws[1 + P] !== 10'd1) begin bad++; $display("FAIL abort_fresh_ws got=%0d want=1", q_ws[1 + P]); end
    endtask

    task automatic test_busy_start_and_reset();
        pulse_start(100, 2);
        capture(2 * P + 6, 30, 7);
        for (int c = 1; c < q_tx.size(); c++) begin
            total++;
            if (q_tx[c] !== exp_tx(c, 100, 2)) begin bad++; $display("FAIL busy_tx c=%0d got=%b want=%b", c, q_tx[c], exp_tx(c, 100, 2)); end
            total++;
            if (q_en[c] !== exp_en(c, 2)) begin bad++; $display("FAIL busy_en c=%0d got=%b want=%b", c, q_en[c], exp_en(c, 2)); end
            if (exp_en(c, 2) == 1'b0) begin
                total++;
                if (q_addr[c] !== 9'((100 + (c - 1) / P) % 512)) begin
                    bad++; $display("FAIL busy_addr c=%0d got=%0d want=%0d", c, q_addr[c], (100 + (c - 1) / P) % 512);
                end
            end
        end
        total++; if (done_cyc != 1 + 2 * P) begin bad++; $display("FAIL busy_done_cycle got=%0d want=%0d", done_cyc, 1 + 2 * P); end
        total++; if (n_done != 1) begin bad++; $display("FAIL busy_done_pulses got=%0d want=1", n_done); end
        total++; if (q_ws[1 + 2 * P] !== 10'd2) begin bad++; $display("FAIL busy_ws got=%0d want=2", q_ws[1 + 2 * P]); end
        // Reset in the start bit of the second word.
        pulse_start(200, 2);
        repeat (77) tick();
        total++; if (tx_out !== 1'b0) begin bad++; $display("FAIL rst_pre_tx got=%b want=0", tx_out); end
        total++; if (words_sent !== 10'd1) begin bad++; $display("FAIL rst_pre_ws got=%0d want=1", words_sent); end
        soc_rst = 1'b1;
        tick();
        soc_rst = 1'b0;
        total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b want=1", tx_out); end
        total++; if (io_oeb !== 1'b1) begin bad++; $display("FAIL rst_oeb got=%b want=1", io_oeb); end
        total++; if (en_to_memB !== 1'b1) begin bad++; $display("FAIL rst_en got=%b want=1", en_to_memB); end
        total++; if (addr_to_mem !== 9'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", addr_to_mem); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (words_sent !== 10'd0) begin bad++; $display("FAIL rst_ws got=%0d want=0", words_sent); end
        repeat (C + 2) tick();
        total++; if (busy !== 1'b0 || tx_out !== 1'b1) begin bad++; $display("FAIL rst_stays_idle busy=%b tx=%b want busy=0 tx=1", busy, tx_out); end
    endtask

    task automatic test_random();
        int sa;
        int wc;
        for (int n = 0; n < 6; n++) begin
            sa = int'($urandom_range(0, 511));
            wc = int'($urandom_range(1, 3));
            for (int k = 0; k < wc; k++) mem[(sa + k) % 512] = 16'($urandom);
            pulse_start(sa, wc);
            capture(wc * P + 6, -1, 0);
            for (int c = 1; c < q_tx.size(); c++) begin
                total++;
                if (q_tx[c] !== exp_tx(c, sa, wc)) begin bad++; $display("FAIL rand_tx n=%0d c=%0d got=%b want=%b", n, c, q_tx[c], exp_tx(c, sa, wc)); end
                total++;
                if (q_en[c] !== exp_en(c, wc)) begin bad++; $display("FAIL rand_en n=%0d c=%0d got=%b want=%b", n, c, q_en[c], exp_en(c, wc)); end
                if (exp_en(c, wc) == 1'b0) begin
                    total++;
                    if (q_addr[c] !== 9'((sa + (c - 1) / P) % 512)) begin
                        bad++; $display("FAIL rand_addr n=%0d c=%0d got=%0d want=%0d", n, c, q_addr[c], (sa + (c - 1) / P) % 512);
                    end
                end
                if (c <= 1 + wc * P) begin
                    total++;
                    if (q_busy[c] !== 1'b1 || q_oeb[c] !== 1'b0) begin
                        bad++; $display("FAIL rand_active n=%0d c=%0d busy=%b oeb=%b want busy=1 oeb=0", n, c, q_busy[c], q_oeb[c]);
                    end
                end
            end
            total++; if (done_cyc != 1 + wc * P) begin bad++; $display("FAIL rand_done_cycle n=%0d got=%0d want=%0d", n, done_cyc, 1 + wc * P); end
            total++; if (n_done != 1) begin bad++; $display("FAIL rand_done_pulses n=%0d got=%0d want=1", n, n_done); end
            total++; if (q_ws[1 + wc * P] !== 10'(wc)) begin bad++; $display("FAIL rand_ws n=%0d got=%0d want=%0d", n, q_ws[1 + wc * P], wc); end
            total++; if (q_busy[wc * P + 6] !== 1'b0) begin bad++; $display("FAIL rand_idle n=%0d got=%b want=0", n, q_busy[wc * P + 6]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
        test_reset();
        test_single_word();
        test_wrap();
        test_zero_count();
        test_abort();
        test_busy_start_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_readback.md
Name: mem_readback

Overview:
- Logic-analyzer-triggered read-back engine for one 512x16 OpenRAM-style data memory.
- It reads a contiguous block of words through the active-low memory port, the same port the LA/CPU write path drives.
- Each word is sent out one IO pad as a UART-style serial frame, so memory contents loaded by the LA can be verified off-chip.
- It sits beside the per-CPU memory switch and runs from the SoC clock/reset.

Parameters:
CLKS_PER_BIT, 4, soc_clk cycles per serial bit (legal values 2..65535)
ADDR_W, 9, memory word-address width
DATA_W, 16, memory word width

Ports:
soc_clk  input  1  SoC clock; all logic is on its rising edge
soc_rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a transfer when in IDLE
abort  input  1  synchronous abort; returns the block to IDLE
start_addr  input  ADDR_W  first word address, sampled on an accepted start
word_count  input  ADDR_W+1  number of words to send (0..512), sampled on an accepted start
addr_to_mem  output  ADDR_W  memory address
en_to_memB  output  1  active-low memory chip enable
rw_to_mem  output  1  active-low write enable; always 1 (read only)
data_from_mem  input  DATA_W  memory read data, valid the cycle after en_to_memB=0
tx_out  output  1  serial data pad; idles at 1
io_oeb  output  1  active-low pad output enable
busy  output  1  high from the cycle after an accepted start until return to IDLE
done  output  1  one-cycle pulse at normal completion
words_sent  output  ADDR_W+1  count of words whose stop bit has completed in the current/last transfer

Behaviour:
- Reset values (soc_rst=1, applied at the clock edge):
  - tx_out=1, io_oeb=1, en_to_memB=1, rw_to_mem=1, addr_to_mem=0.
  - busy=0, done=0, words_sent=0, state=IDLE.
  - Reset mid-frame takes effect at the next edge, with no partial-bit completion.
- States: IDLE, REQ, CAPT, SHIFT, DONE.
- IDLE:
  - start=1 with word_count!=0: latch start_addr and word_count, clear words_sent, go to REQ.
  - start=1 with word_count=0: go to DONE with no memory access and words_sent=0.
  - start while not in IDLE is ignored.
- REQ (1 cycle): en_to_memB=0, addr_to_mem=current address → CAPT.
- CAPT (1 cycle):
  - en_to_memB=1.
  - data_from_mem is latched into the shift register at the end of this cycle.
  - Bit counter and divider are cleared → SHIFT.
- SHIFT:
  - Sends an 18-bit frame: start bit 0, then DATA_W data bits LSB first, then stop bit 1.
  - Each bit is held for exactly CLKS_PER_BIT cycles; tx_out is registered.
  - At the last cycle of the stop bit, words_sent increments.
  - If words remain: address increments (9-bit, wraps 511→0) → REQ.
  - Otherwise → DONE.
- DONE (1 cycle): done=1 → IDLE. busy stays 1 during DONE.
- Pad enable: io_oeb=0 whenever state!=IDLE, otherwise 1. tx_out=1 in every state other than SHIFT.
- Timing, with an accepted start in cycle 0:
  - REQ is cycle 1, CAPT is cycle 2.
  - The start bit begins in cycle 3.
  - The stop bit ends in cycle 2+18·CLKS_PER_BIT.
  - The next REQ (or DONE) follows immediately.
  - Each word costs 2+18·CLKS_PER_BIT cycles.
- Abort:
  - abort=1 in any non-IDLE state → IDLE at the next edge: tx_out=1, en_to_memB=1, io_oeb=1.
  - done is not pulsed; words_sent holds its value.
  - abort and start in the same IDLE cycle: abort wins and the start is dropped.
- start coinciding with DONE is ignored.
- word_count=512 sends all words, wrapping the address past 511.
- rw_to_mem is never driven low.

Test Plan:
1. Reset, then single word: CLKS_PER_BIT=4, memory[5]=16'hA5C3, start with start_addr=5, word_count=1.
   - Cycle 1: en_to_memB=0 and addr_to_mem=5.
   - Cycles 3-6: tx_out=0.
   - Following 64 cycles carry 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB first), 4 cycles per bit.
   - Cycles 71-74: tx_out=1.
   - Cycle 75: done=1; words_sent=1.
2. Multi-word wrap: start_addr=510, word_count=3, memory[510]=1, memory[511]=2, memory[0]=3.
   - REQ addresses are 510, 511, 0, with REQs spaced 74 cycles apart.
   - Decoded words are 1, 2, 3; words_sent=3; one done pulse.
3. Zero count: word_count=0 → done in cycle 1; en_to_memB stays 1 throughout; io_oeb=0 for that one cycle only; words_sent=0.
4. Abort mid-frame: abort at cycle 20 of word 0 → next cycle tx_out=1, io_oeb=1, busy=0; no done pulse; words_sent=0; a fresh start then works normally.
5. Start while busy and reset mid-frame:
   - A second start pulsed during SHIFT is ignored; addresses and count are unchanged.
   - soc_rst asserted mid-frame → all outputs at reset values at the next edge.
6. rw_to_mem monitor: rw_to_mem=1 in every cycle across all of the above scenarios.
